// File: rtl/spice_node_integrator.sv
// Per-node voltage integrator: sums terminal currents, integrates into a clamped node voltage.
// Defining SPICE_NODE_PIPE_EN registers the current sum first, giving a 2-cycle update with busy.
`ifndef W
`define W 15
`endif
`ifndef HI
`define HI 16384
`endif
`ifndef LO
`define LO (-16384)
`endif

module spice_node_integrator #(
  parameter int N_TERM     = 4,
  parameter int CAP_SHIFT  = 2,
  parameter int SETTLE_TOL = 2,
  parameter int SETTLE_CNT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step,
  input  logic                     init,
  input  logic signed [`W:0]       v_init,
  input  logic [N_TERM*(`W+1)-1:0] i_bus,
  output logic signed [`W:0]       v,
  output logic                     sat_hi,
  output logic                     sat_lo,
  output logic                     settled,
  output logic                     busy
);

  localparam int unsigned VW = `W + 1;
  localparam int unsigned SW = VW + $clog2(N_TERM);
  localparam int unsigned XW = SW + 1;
  localparam int unsigned CW = $clog2(SETTLE_CNT + 1);

  localparam logic signed [VW-1:0] V_HI    = VW'(`HI);
  localparam logic signed [VW-1:0] V_LO    = VW'(`LO);
  localparam logic signed [XW-1:0] X_HI    = XW'(`HI);
  localparam logic signed [XW-1:0] X_LO    = XW'(`LO);
  localparam logic signed [SW-1:0] TOL_P   = SW'(SETTLE_TOL);
  localparam logic signed [SW-1:0] TOL_N   = SW'(-SETTLE_TOL);
  localparam logic [CW-1:0]        CNT_MAX = CW'(SETTLE_CNT);

  logic signed [SW-1:0] ext [N_TERM];
  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] upd_sum_c;
  logic signed [SW-1:0] delta_c;
  logic signed [XW-1:0] vn_c;
  logic                 upd_en_c;
  logic                 quiet_c;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nx_c;

  function automatic logic signed [VW-1:0] clamp(input logic signed [XW-1:0] x);
    if (x > X_HI)      clamp = V_HI;
    else if (x < X_LO) clamp = V_LO;
    else               clamp = VW'(x);
  endfunction

  // Sign-extend each terminal to the growth-safe width before summing.
  for (genvar k = 0; k < N_TERM; k++) begin : g_ext
    logic signed [VW-1:0] term;
    assign term   = i_bus[k*VW +: VW];
    assign ext[k] = SW'(term);
  end

  always_comb begin
    sum_c = '0;
    for (int k = 0; k < N_TERM; k++) begin
      sum_c = sum_c + ext[k];
    end
  end

`ifdef SPICE_NODE_PIPE_EN
  logic signed [SW-1:0] sum_q;
  logic                 busy_q;

  // Capture the sum on an accepted step; apply it on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      busy_q <= 1'b0;
    end else if (init) begin
      busy_q <= 1'b0;
    end else if (busy_q) begin
      busy_q <= 1'b0;
    end else if (step) begin
      sum_q  <= sum_c;
      busy_q <= 1'b1;
    end
  end

  assign upd_sum_c = sum_q;
  assign upd_en_c  = busy_q;
  assign busy      = busy_q;
`else
  assign upd_sum_c = sum_c;
  assign upd_en_c  = step;
  assign busy      = 1'b0;
`endif

  // Quiet test uses the unclamped delta so a pinned rail node can still settle.
  always_comb begin
    delta_c  = upd_sum_c >>> CAP_SHIFT;
    vn_c     = XW'(v) + XW'(delta_c);
    quiet_c  = (delta_c >= TOL_N) && (delta_c <= TOL_P);
    cnt_nx_c = '0;
    if (quiet_c) begin
      cnt_nx_c = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v       <= V_LO;
      cnt     <= '0;
      settled <= 1'b0;
    end else if (init) begin
      v       <= clamp(XW'(v_init));
      cnt     <= '0;
      settled <= 1'b0;
    end else if (upd_en_c) begin
      v       <= clamp(vn_c);
      cnt     <= cnt_nx_c;
      settled <= (cnt_nx_c == CNT_MAX);
    end
  end

  assign sat_hi = (v == V_HI);
  assign sat_lo = (v == V_LO);

endmodule

// File: tb/tb_spice_node_integrator.sv
// Scoreboard bench for spice_node_integrator: directed steps push expected node state, a monitor checks it.
`ifndef W
`define W 15
`endif
`ifndef HI
`define HI 16384
`endif
`ifndef LO
`define LO (-16384)
`endif

module tb_spice_node_integrator;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    step;
  logic                    init;
  logic signed [`W:0]      v_init;
  logic [4*(`W+1)-1:0]     i_bus;
  logic signed [`W:0]      v;
  logic                    sat_hi;
  logic                    sat_lo;
  logic                    settled;
  logic                    busy;

  spice_node_integrator dut (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .init    (init),
    .v_init  (v_init),
    .i_bus   (i_bus),
    .v       (v),
    .sat_hi  (sat_hi),
    .sat_lo  (sat_lo),
    .settled (settled),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    string name;
    bit    chk_v;
    int    ev;
    bit    es;
    bit    eb;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic cmp(input string name, input string what, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s %s: got %0d expected %0d (t=%0t)", name, what, act, exp, $time);
  endtask

  // Monitor: compare every expectation whose due cycle has been reached.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk_v) begin
        cmp(e.name, "v", int'(v), e.ev);
        cmp(e.name, "sat_hi", int'(sat_hi), int'(e.ev == `HI));
        cmp(e.name, "sat_lo", int'(sat_lo), int'(e.ev == `LO));
        cmp(e.name, "settled", int'(settled), int'(e.es));
      end
      cmp(e.name, "busy", int'(busy), int'(e.eb));
    end
  end

  task automatic expect_v(input int due, input string name, input int ev, input bit es, input bit eb);
    exp_t e;
    e.due = due; e.name = name; e.chk_v = 1'b1; e.ev = ev; e.es = es; e.eb = eb;
    q.push_back(e);
  endtask

  task automatic expect_busy(input int due, input string name);
    exp_t e;
    e.due = due; e.name = name; e.chk_v = 1'b0; e.ev = 0; e.es = 1'b0; e.eb = 1'b1;
    q.push_back(e);
  endtask

  task automatic drive(input bit ini, input bit stp, input int vi,
                       input int c0, input int c1, input int c2, input int c3);
    @(negedge clk);
    init   = ini;
    step   = stp;
    v_init = (`W+1)'(vi);
    i_bus  = {(`W+1)'(c3), (`W+1)'(c2), (`W+1)'(c1), (`W+1)'(c0)};
  endtask

  task automatic do_init(input int vi, input int ev, input string name);
    drive(1'b1, 1'b0, vi, 0, 0, 0, 0);
    expect_v(cyc + 1, name, ev, 1'b0, 1'b0);
  endtask

  task automatic do_step(input int c0, input int c1, input int c2, input int c3,
                         input int ev, input bit es, input string name);
    drive(1'b0, 1'b1, 0, c0, c1, c2, c3);
`ifdef SPICE_NODE_PIPE_EN
    expect_busy(cyc + 1, {name, "_busy"});
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
`endif
    expect_v(cyc + 1, name, ev, es, 1'b0);
  endtask

  initial begin
    reset  = 1'b1;
    step   = 1'b0;
    init   = 1'b0;
    v_init = '0;
    i_bus  = '0;
    expect_v(1, "reset_state", `LO, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;

    // Reset mid-run, with an update in flight.
    do_init(500, 500, "init_500");
    drive(1'b0, 1'b1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    step = 1'b0;
    expect_v(cyc, "reset_mid", `LO, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    expect_v(cyc + 1, "reset_hold", `LO, 1'b0, 1'b0);

    do_init(0, 0, "init_0");
    do_step(100, 20, -20, 0, 25, 1'b0, "sum100");

    do_init(16380, 16380, "init_16380");
    do_step(100, 100, 100, 100, 16384, 1'b0, "clamp_hi");
    do_step(-100, -100, -100, -100, 16284, 1'b0, "leave_hi");
    do_init(20000, 16384, "init_clamp_hi");
    do_init(-16380, -16380, "init_m16380");
    do_step(-100, -100, -100, -100, -16384, 1'b0, "clamp_lo");

    do_init(0, 0, "init_floor");
    do_step(3, 0, 0, 0, 0, 1'b0, "pos3_floor");
    do_step(-3, 0, 0, 0, -1, 1'b0, "neg3_floor");

    // Seven quiet steps, then init+step must clear the count and discard the step.
    do_init(0, 0, "init_pre");
    for (int k = 1; k <= 7; k++) do_step(1, 1, 1, 1, k, 1'b0, $sformatf("quiet_pre_%0d", k));
    drive(1'b1, 1'b1, -20000, 100, 100, 100, 100);
    expect_v(cyc + 1, "init_over_step", `LO, 1'b0, 1'b0);
`ifdef SPICE_NODE_PIPE_EN
    drive(1'b0, 1'b1, 0, 1, 1, 1, 1);
    expect_busy(cyc + 1, "pipe_busy");
    drive(1'b0, 1'b1, 0, 100, 100, 100, 100);
    expect_v(cyc + 1, "busy_step_ignored", -16383, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    expect_v(cyc + 1, "single_update", -16383, 1'b0, 1'b0);
    do_init(0, 0, "init_cancel");
    drive(1'b0, 1'b1, 0, 100, 100, 100, 100);
    expect_busy(cyc + 1, "cancel_busy");
    drive(1'b1, 1'b0, 7, 0, 0, 0, 0);
    expect_v(cyc + 1, "init_cancels", 7, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    expect_v(cyc + 1, "cancel_hold", 7, 1'b0, 1'b0);
`else
    do_step(1, 1, 1, 1, -16383, 1'b0, "after_init_step");
    do_step(100, 100, 100, 100, -16283, 1'b0, "second_step");
`endif

    do_init(0, 0, "init_settle");
    for (int k = 1; k <= 8; k++) do_step(1, 1, 1, 1, k, (k == 8), $sformatf("settle_%0d", k));
    do_step(3, 3, 3, 3, 11, 1'b0, "unsettle");

    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
